// File: rtl/bob_retire_ctl.sv
// Retire-side consumer of the branch order buffer: reads the head entry, waits for the
// ROB to retire the matching branch, then pops the entry or raises a mispredict redirect.
module bob_retire_ctl #(
  parameter int DATA_WIDTH = 64,
  parameter int TGT_W      = 44
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  hasRetire,
  input  logic [5:0]            retire_addr,
  output logic                  doRetire,
  output logic                  read_clkEn,
  output logic [5:0]            read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  rob_retire_en,
  input  logic [5:0]            rob_retire_tag,
  output logic                  rob_stall,
  output logic                  mispred_except,
  output logic [TGT_W-1:0]      mispred_target,
  output logic [5:0]            mispred_tag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    EXC  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [5:0]       head_tag_reg, head_tag_next;
  logic [TGT_W-1:0] tgt_reg, tgt_next;
  logic [5:0]       mtag_reg, mtag_next;

  logic             entry_resolved;
  logic             entry_mispred;
  logic [TGT_W-1:0] entry_target;
  logic             tag_match;
  logic             retire_fire;

  assign entry_resolved = read_data[0];
  assign entry_mispred  = read_data[1];
  assign entry_target   = read_data[TGT_W+1:2];

  generate
    if (DATA_WIDTH > TGT_W + 2) begin : g_spare_bits
      logic unused_upper;
      assign unused_upper = ^read_data[DATA_WIDTH-1:TGT_W+2];
    end
  endgenerate

  // read_data is live from the RAM, so a resolution write is picked up without a re-read.
  assign tag_match   = rob_retire_en && (rob_retire_tag == head_tag_reg);
  assign retire_fire = (state_reg == HOLD) && tag_match && entry_resolved && hasRetire && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      head_tag_reg <= '0;
      tgt_reg      <= '0;
      mtag_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      head_tag_reg <= head_tag_next;
      tgt_reg      <= tgt_next;
      mtag_reg     <= mtag_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    head_tag_next  = head_tag_reg;
    tgt_next       = tgt_reg;
    mtag_next      = mtag_reg;
    doRetire       = 1'b0;
    read_clkEn     = 1'b0;
    read_addr      = head_tag_reg;
    mispred_except = 1'b0;
    rob_stall      = rob_retire_en && !retire_fire;

    case (state_reg)
      IDLE: begin
        read_addr  = retire_addr;
        read_clkEn = hasRetire && !flush;
        if (hasRetire && !flush) begin
          head_tag_next = retire_addr;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        // A dropped hasRetire means the allocator was reset under us; abandon the entry.
        if (flush || !hasRetire) begin
          state_next = IDLE;
        end else if (retire_fire) begin
          doRetire = 1'b1;
          if (entry_mispred) begin
            tgt_next   = entry_target;
            mtag_next  = head_tag_reg;
            state_next = EXC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      EXC: begin
        mispred_except = !flush;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Combinational outputs are forced quiet while reset is held.
    if (!rst) begin
      doRetire       = 1'b0;
      read_clkEn     = 1'b0;
      read_addr      = '0;
      rob_stall      = 1'b0;
      mispred_except = 1'b0;
    end
  end

  assign mispred_target = tgt_reg;
  assign mispred_tag    = mtag_reg;

endmodule

// File: tb/tb_bob_retire_ctl.sv
// Bench for bob_retire_ctl: BOB RAM model plus a queue of expected retirements.
module tb_bob_retire_ctl;
  localparam int DW = 64;
  localparam int TW = 44;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          hasRetire = 1'b0;
  logic [5:0]    retire_addr = '0;
  logic          doRetire;
  logic          read_clkEn;
  logic [5:0]    read_addr;
  logic [DW-1:0] read_data;
  logic          rob_retire_en = 1'b0;
  logic [5:0]    rob_retire_tag = '0;
  logic          rob_stall;
  logic          mispred_except;
  logic [TW-1:0] mispred_target;
  logic [5:0]    mispred_tag;

  typedef struct packed {
    logic [5:0]    tag;
    logic          mis;
    logic [TW-1:0] tgt;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] mem [0:63];
  logic [5:0]    lat_addr = '0;

  bob_retire_ctl #(.DATA_WIDTH(DW), .TGT_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hasRetire(hasRetire), .retire_addr(retire_addr),
    .doRetire(doRetire), .read_clkEn(read_clkEn), .read_addr(read_addr), .read_data(read_data),
    .rob_retire_en(rob_retire_en), .rob_retire_tag(rob_retire_tag), .rob_stall(rob_stall),
    .mispred_except(mispred_except), .mispred_target(mispred_target), .mispred_tag(mispred_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (read_clkEn) lat_addr <= read_addr;
  assign read_data = mem[lat_addr];

  function automatic logic [DW-1:0] mk(input logic r, input logic m, input logic [TW-1:0] t);
    logic [DW-1:0] e;
    e = '0;
    e[0] = r;
    e[1] = m;
    e[TW+1:2] = t;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take_head(input logic [5:0] a);
    hasRetire = 1'b1; retire_addr = a; rob_retire_en = 1'b0;
    tick();
  endtask

  task automatic drain();
    hasRetire = 1'b0; rob_retire_en = 1'b0; flush = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    hasRetire = 1'b1; retire_addr = 6'd9; rob_retire_en = 1'b1; rob_retire_tag = 6'd9;
    tick(); #1;
    checks++;
    if ({doRetire, read_clkEn, read_addr, rob_stall, mispred_except, mispred_tag, mispred_target} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got do=%b en=%b ra=%0d st=%b exc=%b tag=%0d tgt=%0h want all 0",
               doRetire, read_clkEn, read_addr, rob_stall, mispred_except, mispred_tag, mispred_target);
    end
    hasRetire = 1'b0; rob_retire_en = 1'b0;
    rst = 1'b1;
    tick(); #1;
    checks++;
    if ({read_clkEn, rob_stall, doRetire} !== 3'b000) begin
      errors++; $display("FAIL reset_release got en=%b st=%b do=%b want 000", read_clkEn, rob_stall, doRetire);
    end
  endtask

  task automatic test_basic();
    mem[5] = mk(1'b1, 1'b0, '0);
    hasRetire = 1'b1; retire_addr = 6'd5; #1;
    checks++;
    if ({read_clkEn, read_addr, doRetire} !== {1'b1, 6'd5, 1'b0}) begin
      errors++; $display("FAIL basic_read got en=%b addr=%0d do=%b want 1 5 0", read_clkEn, read_addr, doRetire);
    end
    tick();
    rob_retire_en = 1'b1; rob_retire_tag = 6'd5;
    exp_q.push_back('{tag: 6'd5, mis: 1'b0, tgt: '0}); #1;
    cur = '{tag: 6'h3f, mis: 1'b1, tgt: '1};
    checks++;
    if (doRetire !== 1'b1 || rob_stall !== 1'b0) begin
      errors++; $display("FAIL basic_retire got do=%b stall=%b want 1 0", doRetire, rob_stall);
    end else cur = exp_q.pop_front();
    tick();
    rob_retire_en = 1'b0; retire_addr = 6'd6; #1;
    checks++;
    if ({doRetire, mispred_except, read_clkEn} !== {1'b0, cur.mis, 1'b1}) begin
      errors++; $display("FAIL basic_after got do=%b exc=%b en=%b want 0 %b 1", doRetire, mispred_except, read_clkEn, cur.mis);
    end
    drain();
  endtask

  task automatic test_mispredict();
    mem[12] = mk(1'b1, 1'b1, 44'h1234);
    take_head(6'd12);
    rob_retire_en = 1'b1; rob_retire_tag = 6'd12;
    exp_q.push_back('{tag: 6'd12, mis: 1'b1, tgt: 44'h1234}); #1;
    cur = '{tag: 6'h3f, mis: 1'b0, tgt: '0};
    checks++;
    if (doRetire !== 1'b1) begin
      errors++; $display("FAIL mis_retire got do=%b want 1", doRetire);
    end else cur = exp_q.pop_front();
    tick();
    hasRetire = 1'b0; rob_retire_en = 1'b0; #1;
    checks++;
    if ({mispred_except, mispred_target, mispred_tag, doRetire} !== {cur.mis, cur.tgt, cur.tag, 1'b0}) begin
      errors++; $display("FAIL mis_exc got exc=%b tgt=%0h tag=%0d do=%b want %b %0h %0d 0",
                         mispred_except, mispred_target, mispred_tag, doRetire, cur.mis, cur.tgt, cur.tag);
    end
    tick();
    checks++;
    if ({mispred_except, mispred_target, mispred_tag} !== {1'b0, cur.tgt, cur.tag}) begin
      errors++; $display("FAIL mis_hold got exc=%b tgt=%0h tag=%0d want 0 %0h %0d",
                         mispred_except, mispred_target, mispred_tag, cur.tgt, cur.tag);
    end
    drain();
  endtask

  task automatic test_unresolved();
    mem[3] = mk(1'b0, 1'b0, '0);
    take_head(6'd3);
    rob_retire_en = 1'b1; rob_retire_tag = 6'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({rob_stall, doRetire} !== 2'b10) begin
        errors++; $display("FAIL unres_stall cyc%0d got stall=%b do=%b want 1 0", i, rob_stall, doRetire);
      end
      tick();
    end
    mem[3] = mk(1'b1, 1'b0, '0);
    exp_q.push_back('{tag: 6'd3, mis: 1'b0, tgt: '0}); #1;
    cur = '{tag: 6'h3f, mis: 1'b1, tgt: '1};
    checks++;
    if ({rob_stall, doRetire} !== 2'b01) begin
      errors++; $display("FAIL unres_resolve got stall=%b do=%b want 0 1", rob_stall, doRetire);
    end else cur = exp_q.pop_front();
    tick();
    hasRetire = 1'b0; rob_retire_en = 1'b0; #1;
    checks++;
    if (mispred_except !== cur.mis) begin
      errors++; $display("FAIL unres_exc got %b want %b", mispred_except, cur.mis);
    end
    drain();
  endtask

  task automatic test_mismatch();
    mem[7] = mk(1'b1, 1'b0, '0);
    take_head(6'd7);
    rob_retire_en = 1'b1; rob_retire_tag = 6'd8;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({rob_stall, doRetire, read_clkEn} !== 3'b100) begin
        errors++; $display("FAIL mismatch cyc%0d got stall=%b do=%b en=%b want 1 0 0", i, rob_stall, doRetire, read_clkEn);
      end
      tick();
    end
    rob_retire_tag = 6'd7;
    exp_q.push_back('{tag: 6'd7, mis: 1'b0, tgt: '0}); #1;
    checks++;
    if (doRetire !== 1'b1) begin
      errors++; $display("FAIL mismatch_then_match got do=%b want 1", doRetire);
    end else cur = exp_q.pop_front();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0] addrs [3];
    int last;
    addrs[0] = 6'd46; addrs[1] = 6'd47; addrs[2] = 6'd0;
    last = 0;
    cur = '{tag: 6'h3f, mis: 1'b1, tgt: '1};
    for (int i = 0; i < 3; i++) begin
      mem[addrs[i]] = mk(1'b1, 1'b0, '0);
      hasRetire = 1'b1; retire_addr = addrs[i];
      rob_retire_en = 1'b1; rob_retire_tag = addrs[i]; #1;
      checks++;
      if ({read_addr, read_clkEn, rob_stall, doRetire} !== {addrs[i], 3'b110}) begin
        errors++; $display("FAIL wrap_idle%0d got addr=%0d en=%b stall=%b do=%b want %0d 1 1 0",
                           i, read_addr, read_clkEn, rob_stall, doRetire, addrs[i]);
      end
      if (i > 0) begin
        checks++;
        if (mispred_except !== cur.mis) begin
          errors++; $display("FAIL wrap_exc%0d got %b want %b", i, mispred_except, cur.mis);
        end
      end
      tick();
      exp_q.push_back('{tag: addrs[i], mis: 1'b0, tgt: '0}); #1;
      checks++;
      if (doRetire !== 1'b1) begin
        errors++; $display("FAIL wrap_retire%0d got do=%b want 1", i, doRetire);
      end else cur = exp_q.pop_front();
      if (i > 0) begin
        checks++;
        if (cyc - last !== 2) begin
          errors++; $display("FAIL wrap_spacing%0d got %0d want 2", i, cyc - last);
        end
      end
      last = cyc;
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    mem[9] = mk(1'b1, 1'b0, '0);
    take_head(6'd9);
    rob_retire_en = 1'b1; rob_retire_tag = 6'd9; flush = 1'b1; #1;
    checks++;
    if ({doRetire, rob_stall} !== 2'b01) begin
      errors++; $display("FAIL flush_match got do=%b stall=%b want 0 1", doRetire, rob_stall);
    end
    tick();
    flush = 1'b0; rob_retire_en = 1'b0; #1;
    checks++;
    if ({read_clkEn, doRetire} !== 2'b10) begin
      errors++; $display("FAIL flush_idle got en=%b do=%b want 1 0", read_clkEn, doRetire);
    end
    tick();
    rob_retire_en = 1'b1;
    exp_q.push_back('{tag: 6'd9, mis: 1'b0, tgt: '0}); #1;
    checks++;
    if (doRetire !== 1'b1) begin
      errors++; $display("FAIL flush_reretire got do=%b want 1", doRetire);
    end else cur = exp_q.pop_front();
    drain();
    mem[14] = mk(1'b1, 1'b1, 44'h55);
    take_head(6'd14);
    rob_retire_en = 1'b1; rob_retire_tag = 6'd14;
    exp_q.push_back('{tag: 6'd14, mis: 1'b1, tgt: 44'h55}); #1;
    if (doRetire === 1'b1) cur = exp_q.pop_front();
    tick();
    hasRetire = 1'b0; rob_retire_en = 1'b0; flush = 1'b1; #1;
    checks++;
    if ({mispred_except, mispred_target} !== {1'b0, 44'h55}) begin
      errors++; $display("FAIL flush_exc got exc=%b tgt=%0h want 0 55", mispred_except, mispred_target);
    end
    tick();
    flush = 1'b0; #1;
    checks++;
    if (mispred_except !== 1'b0) begin
      errors++; $display("FAIL flush_exc_late got %b want 0", mispred_except);
    end
    drain();
  endtask

  task automatic test_has_retire_drop();
    mem[20] = mk(1'b1, 1'b0, '0);
    take_head(6'd20);
    hasRetire = 1'b0; rob_retire_en = 1'b1; rob_retire_tag = 6'd20; #1;
    checks++;
    if ({doRetire, rob_stall} !== 2'b01) begin
      errors++; $display("FAIL drop_hold got do=%b stall=%b want 0 1", doRetire, rob_stall);
    end
    tick();
    hasRetire = 1'b1; retire_addr = 6'd21; #1;
    checks++;
    if ({read_clkEn, read_addr, doRetire} !== {1'b1, 6'd21, 1'b0}) begin
      errors++; $display("FAIL drop_idle got en=%b addr=%0d do=%b want 1 21 0", read_clkEn, read_addr, doRetire);
    end
    hasRetire = 1'b0;
    drain();
  endtask

  task automatic test_reset_exc();
    mem[30] = mk(1'b1, 1'b1, 44'hABC);
    take_head(6'd30);
    rob_retire_en = 1'b1; rob_retire_tag = 6'd30;
    exp_q.push_back('{tag: 6'd30, mis: 1'b1, tgt: 44'hABC}); #1;
    if (doRetire === 1'b1) cur = exp_q.pop_front();
    tick();
    checks++;
    if ({mispred_except, mispred_target} !== {cur.mis, cur.tgt}) begin
      errors++; $display("FAIL rstexc_pre got exc=%b tgt=%0h want %b %0h", mispred_except, mispred_target, cur.mis, cur.tgt);
    end
    rst = 1'b0; #1;
    checks++;
    if ({doRetire, read_clkEn, read_addr, rob_stall, mispred_except, mispred_tag, mispred_target} !== '0) begin
      errors++;
      $display("FAIL rstexc_outputs got do=%b en=%b ra=%0d st=%b exc=%b tag=%0d tgt=%0h want all 0",
               doRetire, read_clkEn, read_addr, rob_stall, mispred_except, mispred_tag, mispred_target);
    end
    tick();
    rst = 1'b1; hasRetire = 1'b0; rob_retire_en = 1'b0;
    tick();
    checks++;
    if ({mispred_except, doRetire} !== 2'b00) begin
      errors++; $display("FAIL rstexc_after got exc=%b do=%b want 0 0", mispred_except, doRetire);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    cur = '0;
    test_reset();
    test_basic();
    test_mispredict();
    test_unresolved();
    test_mismatch();
    test_back_to_back();
    test_flush();
    test_has_retire_drop();
    test_reset_exc();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
